// File: rtl/coef_load_ctrl.sv
// coef_load_ctrl
// Loads a stream of coefficient words into the dual-channel (L/R)
// coefficient RAM. The words go to consecutive addresses from a base
// address, and the address wraps modulo 2^ADDR_W. busy stays high for the
// whole load so that the FIR engine can stall. done pulses when the load
// ends, and err/err_code report the outcome.
// Optional readback verification: define COEF_VERIFY_EN.
module coef_load_ctrl #(
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 36,
    parameter int TIMEOUT = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        chan,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic [ADDR_W-1:0] addrLrw,
    output logic [ADDR_W-1:0] addrRrw,
    output logic [DATA_W-1:0] datainLrw,
    output logic [DATA_W-1:0] datainRrw,
    output logic              weL,
    output logic              weR,
    input  logic [DATA_W-1:0] dataoutLrw,
    input  logic [DATA_W-1:0] dataoutRrw,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] MAX_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

    localparam logic [1:0] EC_NONE  = 2'b00;
    localparam logic [1:0] EC_COUNT = 2'b01;
    localparam logic [1:0] EC_LEN   = 2'b10;
    localparam logic [1:0] EC_TMO   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_DONE   = 2'd2
`ifdef COEF_VERIFY_EN
        ,
        S_VERIFY = 2'd3
`endif
    } state_t;

    state_t r_state;
    state_t w_next;

    // Command latched at an accepted start.
    logic [1:0]        r_chan;
    logic [ADDR_W-1:0] r_base;
    logic [CNT_W-1:0]  r_cnt;

    // Progress through the load.
    logic [CNT_W-1:0]  r_idx;
    logic [TO_W-1:0]   r_idle;
    logic              r_bad_done;

    // Registered RAM port drive.
    logic [ADDR_W-1:0] r_addrL;
    logic [ADDR_W-1:0] r_addrR;
    logic [DATA_W-1:0] r_dinL;
    logic [DATA_W-1:0] r_dinR;
    logic              r_weL;
    logic              r_weR;

    logic              r_err;
    logic [1:0]        r_err_code;

    logic              w_idle;
    logic              w_load;
    logic              w_verify;
    logic              w_cnt_ok;
    logic              w_start_ok;
    logic              w_start_bad;
    logic              w_xfer;
    logic              w_nth;
    logic              w_early;
    logic              w_tmo;
    logic              w_vend;
    logic              w_vfail;
    logic              w_useL;
    logic              w_useR;
    logic [ADDR_W-1:0] w_idx_addr;

    assign w_idle      = (r_state == S_IDLE);
    assign w_load      = (r_state == S_LOAD);
    assign w_cnt_ok    = (count != '0) && (count <= MAX_CNT);
    assign w_start_ok  = w_idle && start && w_cnt_ok;
    assign w_start_bad = w_idle && start && !w_cnt_ok;

    // s_ready is high for the whole LOAD state, so a transfer is just s_valid.
    assign w_xfer  = w_load && s_valid;
    assign w_nth   = w_xfer && (r_idx == (r_cnt - CNT_W'(1)));
    assign w_early = w_xfer && s_last && !w_nth;
    assign w_tmo   = w_load && !s_valid && (r_idle == TO_LAST);

    // 00 = L only, 01 = R only, 1x = both channels.
    assign w_useL     = (r_chan != 2'b01);
    assign w_useR     = (r_chan != 2'b00);
    assign w_idx_addr = r_base + r_idx[ADDR_W-1:0];

`ifdef COEF_VERIFY_EN
    // Readback works at one address every two cycles. The address is
    // registered into the RAM in the cycle where r_vcyc is even. The RAM
    // output register then shows the word when r_vcyc is even again, two
    // cycles later. The last sample happens at r_vcyc == 2*N.
    logic [CNT_W:0]    r_vcyc;
    logic [DATA_W-1:0] r_csum;
    logic [DATA_W-1:0] r_rdL;
    logic [DATA_W-1:0] r_rdR;
    logic              w_vsample;
    logic              w_vmis;
    logic [ADDR_W-1:0] w_vaddr;
    logic [DATA_W-1:0] w_rdL_fin;
    logic [DATA_W-1:0] w_rdR_fin;

    assign w_verify  = (r_state == S_VERIFY);
    assign w_vend    = w_verify && (r_vcyc == {r_cnt, 1'b0});
    assign w_vsample = w_verify && (r_vcyc != '0) && !r_vcyc[0];
    assign w_vaddr   = r_base + r_vcyc[ADDR_W:1];
    assign w_rdL_fin = r_rdL ^ dataoutLrw;
    assign w_rdR_fin = r_rdR ^ dataoutRrw;
    // The last word is folded in combinationally, so the result is known in
    // the final VERIFY cycle. L and R are checked independently.
    assign w_vmis    = (w_useL && (w_rdL_fin != r_csum)) ||
                       (w_useR && (w_rdR_fin != r_csum));
    assign w_vfail   = w_vend && w_vmis;

    // Checksum of written words, readback accumulation and verify cycle count.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_vcyc <= '0;
            r_csum <= '0;
            r_rdL  <= '0;
            r_rdR  <= '0;
        end else if (w_start_ok) begin
            r_vcyc <= '0;
            r_csum <= '0;
            r_rdL  <= '0;
            r_rdR  <= '0;
        end else begin
            if (w_xfer)
                r_csum <= r_csum ^ s_data;
            if (w_verify)
                r_vcyc <= r_vcyc + 1'b1;
            if (w_vsample) begin
                r_rdL <= w_rdL_fin;
                r_rdR <= w_rdR_fin;
            end
        end
    end
`else
    // Without verification the readback ports are not needed.
    logic w_unused_rd;
    assign w_unused_rd = ^{dataoutLrw, dataoutRrw};
    assign w_verify    = 1'b0;
    assign w_vend      = 1'b0;
    assign w_vfail     = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_start_ok)
                    w_next = S_LOAD;
            end
            S_LOAD: begin
                if (w_nth)
`ifdef COEF_VERIFY_EN
                    w_next = S_VERIFY;
`else
                    w_next = S_DONE;
`endif
                else if (w_early || w_tmo)
                    w_next = S_DONE;
            end
`ifdef COEF_VERIFY_EN
            S_VERIFY: begin
                if (w_vend)
                    w_next = S_DONE;
            end
`endif
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the state.
    always_comb begin
        s_ready = w_load;
        busy    = w_load || w_verify;
        done    = (r_state == S_DONE) || r_bad_done;
    end

    // Command latch, word index and idle (timeout) counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_chan     <= '0;
            r_base     <= '0;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_idle     <= '0;
            r_bad_done <= 1'b0;
        end else begin
            r_bad_done <= w_start_bad;
            if (w_start_ok) begin
                r_chan <= chan;
                r_base <= base_addr;
                r_cnt  <= count;
                r_idx  <= '0;
                r_idle <= '0;
            end else if (w_xfer) begin
                r_idx  <= r_idx + CNT_W'(1);
                r_idle <= '0;
            end else if (w_load) begin
                r_idle <= r_idle + TO_W'(1);
            end
        end
    end

    // RAM port drive. Each write is a one-cycle pulse, and its address and
    // data are registered along with it. A channel that is not used keeps
    // its last address.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_addrL <= '0;
            r_addrR <= '0;
            r_dinL  <= '0;
            r_dinR  <= '0;
            r_weL   <= 1'b0;
            r_weR   <= 1'b0;
        end else begin
            r_weL <= w_xfer && w_useL;
            r_weR <= w_xfer && w_useR;
            if (w_xfer && w_useL) begin
                r_addrL <= w_idx_addr;
                r_dinL  <= s_data;
            end
            if (w_xfer && w_useR) begin
                r_addrR <= w_idx_addr;
                r_dinR  <= s_data;
            end
`ifdef COEF_VERIFY_EN
            if (w_verify && !r_vcyc[0] && !w_vend) begin
                if (w_useL)
                    r_addrL <= w_vaddr;
                if (w_useR)
                    r_addrR <= w_vaddr;
            end
`endif
        end
    end

    // Sticky error status. It is cleared only by an accepted start.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_err      <= 1'b0;
            r_err_code <= EC_NONE;
        end else if (w_start_ok) begin
            r_err      <= 1'b0;
            r_err_code <= EC_NONE;
        end else if (w_start_bad) begin
            r_err      <= 1'b1;
            r_err_code <= EC_COUNT;
        end else if (w_early) begin
            r_err      <= 1'b1;
            r_err_code <= EC_LEN;
        end else if (w_tmo || w_vfail) begin
            r_err      <= 1'b1;
            r_err_code <= EC_TMO;
        end
    end

    assign addrLrw   = r_addrL;
    assign addrRrw   = r_addrR;
    assign datainLrw = r_dinL;
    assign datainRrw = r_dinR;
    assign weL       = r_weL;
    assign weR       = r_weR;
    assign err       = r_err;
    assign err_code  = r_err_code;

endmodule

// File: tb/tb_coef_load_ctrl.sv
// Testbench for coef_load_ctrl. Expected RAM writes go into per-channel
// queues when a word is accepted. A negedge monitor pops an entry for every
// write enable it sees and compares it. A small RAM model supplies the
// readback data that the optional verify path uses.
module tb_coef_load_ctrl;

    localparam int ADDR_W  = 14;
    localparam int DATA_W  = 36;
    localparam int TIMEOUT = 1024;
`ifdef COEF_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [1:0]        chan;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   count;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic [ADDR_W-1:0] addrLrw, addrRrw;
    logic [DATA_W-1:0] datainLrw, datainRrw;
    logic              weL, weR;
    logic [DATA_W-1:0] dataoutLrw, dataoutRrw;
    logic              busy, done, err;
    logic [1:0]        err_code;

    coef_load_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .start(start), .chan(chan),
        .base_addr(base_addr), .count(count), .s_valid(s_valid),
        .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .addrLrw(addrLrw), .addrRrw(addrRrw), .datainLrw(datainLrw),
        .datainRrw(datainRrw), .weL(weL), .weR(weR),
        .dataoutLrw(dataoutLrw), .dataoutRrw(dataoutRrw), .busy(busy),
        .done(done), .err(err), .err_code(err_code)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    wr_t qL[$];
    wr_t qR[$];
    wr_t eL, eR;
    int  n_cmp = 0;
    int  n_mis = 0;
    int  n_weL = 0;
    int  n_weR = 0;

    // RAM model: the write is synchronous and the read output is registered.
    logic [DATA_W-1:0] memL [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] memR [0:(1<<ADDR_W)-1];
    logic              flip_en = 1'b0;
    logic [ADDR_W-1:0] flip_addr = '0;

    always @(posedge clock) begin
        if (weL) memL[addrLrw] <= datainLrw;
        if (weR) memR[addrRrw] <= datainRrw;
        dataoutLrw <= memL[addrLrw] ^ ((flip_en && addrLrw == flip_addr) ? DATA_W'(1) : '0);
        dataoutRrw <= memR[addrRrw];
    end

    // Write monitor / scoreboard.
    always @(negedge clock) begin
        if (weL === 1'b1) begin
            n_weL++;
            n_cmp++;
            if (qL.size() == 0) begin
                n_mis++;
                $display("FAIL wrL_unexpected: got addr %h data %h, required no write", addrLrw, datainLrw);
            end else begin
                eL = qL.pop_front();
                if ({addrLrw, datainLrw} !== eL) begin
                    n_mis++;
                    $display("FAIL wrL: got addr %h data %h, required addr %h data %h", addrLrw, datainLrw, eL.a, eL.d);
                end
            end
        end
        if (weR === 1'b1) begin
            n_weR++;
            n_cmp++;
            if (qR.size() == 0) begin
                n_mis++;
                $display("FAIL wrR_unexpected: got addr %h data %h, required no write", addrRrw, datainRrw);
            end else begin
                eR = qR.pop_front();
                if ({addrRrw, datainRrw} !== eR) begin
                    n_mis++;
                    $display("FAIL wrR: got addr %h data %h, required addr %h data %h", addrRrw, datainRrw, eR.a, eR.d);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [1:0] c, input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] n);
        chan = c; base_addr = b; count = n; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Presents one word and pushes the expected write(s) once it is accepted.
    task automatic send_word(input logic [1:0] c, input logic [ADDR_W-1:0] b, input int idx,
                             input logic [DATA_W-1:0] d, input logic l, output int waits);
        logic acc;
        wr_t  e;
        s_valid = 1'b1; s_data = d; s_last = l; acc = 1'b0; waits = 0;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clock);
            if (s_ready === 1'b1) acc = 1'b1;
            else waits++;
        end
        n_cmp++;
        if (!acc) begin
            n_mis++;
            $display("FAIL accept: word %0d got s_ready %b, required 1", idx, s_ready);
            s_valid = 1'b0;
        end else begin
            e.a = b + ADDR_W'(idx);
            e.d = d;
            if (c != 2'b01) qL.push_back(e);
            if (c != 2'b00) qR.push_back(e);
            tick();
        end
    endtask

    task automatic wait_done(input int max, output bit found, output int cyc);
        found = 1'b0; cyc = 0;
        while (!found && cyc < max) begin
            @(negedge clock);
            cyc++;
            if (done === 1'b1) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({busy, done, err, err_code, weL, weR, s_ready} !== 8'b0) begin
            n_mis++;
            $display("FAIL reset_status: got %b, required 00000000", {busy, done, err, err_code, weL, weR, s_ready});
        end
        n_cmp++;
        if ({addrLrw, addrRrw, datainLrw, datainRrw} !== '0) begin
            n_mis++;
            $display("FAIL reset_ports: got addrL %h addrR %h, required all zero", addrLrw, addrRrw);
        end
        reset = 1'b0;
        tick();
    endtask

    // Loads a command, streams n words continuously and checks the completion.
    task automatic run_load(input string nm, input logic [1:0] c, input logic [ADDR_W-1:0] b,
                            input int n, input int exp_lat);
        int waits, tot, cyc, l0, r0;
        bit found;
        l0 = n_weL; r0 = n_weR; tot = 0;
        issue(c, b, (ADDR_W+1)'(n));
        n_cmp++;
        if (busy !== 1'b1) begin
            n_mis++;
            $display("FAIL %s_busy: got %b, required 1", nm, busy);
        end
        for (int i = 0; i < n; i++) begin
            send_word(c, b, i, DATA_W'({$urandom(), 4'(i)}), (i == n-1), waits);
            tot += waits;
        end
        s_valid = 1'b0; s_last = 1'b0;
        wait_done(60, found, cyc);
        n_cmp++;
        if (!found || cyc != exp_lat) begin
            n_mis++;
            $display("FAIL %s_done: got found %0d after %0d cycles, required %0d", nm, found, cyc, exp_lat);
        end
        n_cmp++;
        if ({err, err_code, busy} !== 4'b0) begin
            n_mis++;
            $display("FAIL %s_status: got err %b code %b busy %b, required 0 00 0", nm, err, err_code, busy);
        end
        tick(); tick();
        n_cmp++;
        if (tot != 0 || qL.size() != 0 || qR.size() != 0 ||
            n_weL - l0 != (c != 2'b01 ? n : 0) || n_weR - r0 != (c != 2'b00 ? n : 0)) begin
            n_mis++;
            $display("FAIL %s_writes: got stalls %0d weL %0d weR %0d pending %0d/%0d, required 0 stalls and all %0d words",
                     nm, tot, n_weL - l0, n_weR - r0, qL.size(), qR.size(), n);
        end
    endtask

    task automatic test_load_l();
        run_load("loadL", 2'b00, 14'h0010, 4, VERIFY ? 10 : 1);
    endtask

    task automatic test_both_wrap();
        run_load("wrap", 2'b10, 14'h3FFE, 4, VERIFY ? 10 : 1);
    endtask

    task automatic test_bad_count();
        logic [ADDR_W:0] bad [2];
        int l0;
        bad[0] = '0;
        bad[1] = 15'd16385;
        for (int i = 0; i < 2; i++) begin
            l0 = n_weL + n_weR;
            issue(2'b10, 14'h0, bad[i]);
            n_cmp++;
            if ({done, err, err_code, busy} !== 5'b11010) begin
                n_mis++;
                $display("FAIL badcnt%0d: got done %b err %b code %b busy %b, required 1 1 01 0", i, done, err, err_code, busy);
            end
            tick(); tick();
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0 || n_weL + n_weR != l0) begin
                n_mis++;
                $display("FAIL badcnt%0d_after: got done %b busy %b writes %0d, required 0 0 0", i, done, busy, n_weL + n_weR - l0);
            end
        end
    endtask

    task automatic test_early_last();
        int waits, cyc, l0;
        bit found;
        l0 = n_weR;
        issue(2'b01, 14'h0100, 15'd8);
        for (int i = 0; i < 3; i++)
            send_word(2'b01, 14'h0100, i, DATA_W'({$urandom(), 4'(i)}), (i == 2), waits);
        s_valid = 1'b0; s_last = 1'b0;
        wait_done(20, found, cyc);
        n_cmp++;
        if (!found || cyc != 1 || err !== 1'b1 || err_code !== 2'b10) begin
            n_mis++;
            $display("FAIL early_last: got found %0d cyc %0d err %b code %b, required 1 1 1 10", found, cyc, err, err_code);
        end
        tick(); tick();
        n_cmp++;
        if (n_weR - l0 != 3 || qR.size() != 0 || s_ready !== 1'b0) begin
            n_mis++;
            $display("FAIL early_writes: got %0d writes ready %b, required 3 writes ready 0", n_weR - l0, s_ready);
        end
    endtask

    task automatic test_back_to_back();
        int waits, cyc;
        bit found;
        issue(2'b00, 14'h0200, 15'd2);
        n_cmp++;
        if (err !== 1'b0 || err_code !== 2'b00) begin
            n_mis++;
            $display("FAIL b2b_clear: got err %b code %b, required 0 00", err, err_code);
        end
        send_word(2'b00, 14'h0200, 0, 36'h1_2345_6789, 1'b0, waits);
        s_valid = 1'b0;
        count = '0; start = 1'b1;
        tick();
        start = 1'b0;
        send_word(2'b00, 14'h0200, 1, 36'hF_EDCB_A987, 1'b1, waits);
        s_valid = 1'b0; s_last = 1'b0;
        wait_done(40, found, cyc);
        n_cmp++;
        if (!found || err !== 1'b0 || err_code !== 2'b00) begin
            n_mis++;
            $display("FAIL b2b_ignored_start: got found %0d err %b code %b, required 1 0 00", found, err, err_code);
        end
        tick();
        run_load("b2b2", 2'b01, 14'h0300, 3, VERIFY ? 8 : 1);
    endtask

    task automatic test_timeout_reset();
        int waits, cyc, w0;
        bit found;
        issue(2'b00, 14'h0040, 15'd2);
        send_word(2'b00, 14'h0040, 0, 36'hC_0FFE_E000, 1'b0, waits);
        s_valid = 1'b0;
        wait_done(TIMEOUT + 20, found, cyc);
        n_cmp++;
        if (!found || cyc != TIMEOUT + 1 || err !== 1'b1 || err_code !== 2'b11) begin
            n_mis++;
            $display("FAIL timeout: got found %0d cyc %0d err %b code %b, required 1 %0d 1 11", found, cyc, err, err_code, TIMEOUT + 1);
        end
        tick();
        w0 = n_weL + n_weR;
        issue(2'b11, 14'h0050, 15'd4);
        send_word(2'b11, 14'h0050, 0, 36'h5_0000_0005, 1'b0, waits);
        send_word(2'b11, 14'h0050, 1, 36'h5_0000_0015, 1'b0, waits);
        s_valid = 1'b1; s_data = 36'hD_EADD_EADD; reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (4) tick();
        n_cmp++;
        if (busy !== 1'b0 || s_ready !== 1'b0 || err !== 1'b0 || done !== 1'b0) begin
            n_mis++;
            $display("FAIL midreset_status: got busy %b ready %b err %b done %b, required 0 0 0 0", busy, s_ready, err, done);
        end
        s_valid = 1'b0;
        n_cmp++;
        if (n_weL + n_weR - w0 != 4 || qL.size() != 0 || qR.size() != 0) begin
            n_mis++;
            $display("FAIL midreset_writes: got %0d writes, required 4", n_weL + n_weR - w0);
        end
    endtask

`ifdef COEF_VERIFY_EN
    task automatic test_verify_flip();
        int waits, cyc;
        bit found;
        flip_en = 1'b1; flip_addr = 14'h0402;
        issue(2'b00, 14'h0400, 15'd4);
        for (int i = 0; i < 4; i++)
            send_word(2'b00, 14'h0400, i, DATA_W'({$urandom(), 4'(i)}), (i == 3), waits);
        s_valid = 1'b0; s_last = 1'b0;
        wait_done(60, found, cyc);
        n_cmp++;
        if (!found || cyc != 10 || err !== 1'b1 || err_code !== 2'b11) begin
            n_mis++;
            $display("FAIL verify_flip: got found %0d cyc %0d err %b code %b, required 1 10 1 11", found, cyc, err, err_code);
        end
        flip_en = 1'b0;
        tick(); tick();
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; chan = '0; base_addr = '0; count = '0;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        test_reset();
        test_load_l();
        test_both_wrap();
        test_bad_count();
        test_early_last();
        test_back_to_back();
        test_timeout_reset();
`ifdef COEF_VERIFY_EN
        test_verify_flip();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
